// File: rtl/mt6835_pkg.sv
// Shared types and constants for the MT6835 read scheduler.
package mt6835_pkg;
    localparam int ANGLE_W  = 21;
    localparam int STATUS_W = 3;
    localparam int FRAME_W  = ANGLE_W + STATUS_W;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        BUSY,
        CHECK
    } state_t;
endpackage

// File: rtl/mt6835_crc8.sv
// Combinational CRC-8 over the 24-bit {angle, status} frame, MSB first,
// no reflection, no final xor.
module mt6835_crc8
    import mt6835_pkg::*;
(
    input  logic [FRAME_W-1:0] i_data,
    output logic [7:0]         o_crc
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = CRC_INIT;
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            if (w_crc[7] ^ i_data[i])
                w_crc = {w_crc[6:0], 1'b0} ^ CRC_POLY;
            else
                w_crc = {w_crc[6:0], 1'b0};
        end
    end

    assign o_crc = w_crc;

endmodule

// File: rtl/mt6835_read_sched.sv
// Periodic MT6835 read pacer: issues reads per tick, CRC-checks frames,
// publishes good angles, counts errors. MT6835_SCHED_RETRY_EN enables immediate re-reads.
module mt6835_read_sched
    import mt6835_pkg::*;
#(
    parameter int PERIOD      = 1000,
    parameter int TIMEOUT     = 512,
    parameter int FAULT_LIMIT = 4,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 16
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_clr_fault,
    output logic                o_rd_start,
    input  logic                i_rd_valid,
    input  logic [ANGLE_W-1:0]  i_rd_angle,
    input  logic [STATUS_W-1:0] i_rd_status,
    input  logic [7:0]          i_rd_crc,
    output logic [ANGLE_W-1:0]  o_angle,
    output logic [STATUS_W-1:0] o_status,
    output logic                o_angle_valid,
    output logic [CNT_W-1:0]    o_crc_err_cnt,
    output logic [CNT_W-1:0]    o_timeout_cnt,
    output logic [CNT_W-1:0]    o_overrun_cnt,
    output logic                o_fault
);

    localparam int TCK_W = $clog2(PERIOD);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CON_W = $clog2(FAULT_LIMIT + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef MT6835_SCHED_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t                r_state, w_next, w_after_bad;
    logic [TCK_W-1:0]      r_tick_cnt;
    logic [TMO_W-1:0]      r_timer;
    logic [CON_W-1:0]      r_consec;
    logic [RTY_W-1:0]      r_retry;
    logic [ANGLE_W-1:0]    r_frm_angle;
    logic [STATUS_W-1:0]   r_frm_status;
    logic [7:0]            r_frm_crc;
    logic [7:0]            w_crc_calc;
    logic                  w_tick, w_crc_ok, w_good, w_bad_crc, w_timeout, w_bad;
    logic                  w_overrun, w_retry_ok;

    mt6835_crc8 u_crc (
        .i_data ({r_frm_angle, r_frm_status}),
        .o_crc  (w_crc_calc)
    );

    assign w_tick     = i_enable && (r_tick_cnt == TCK_W'(PERIOD - 1));
    assign w_crc_ok   = (w_crc_calc == r_frm_crc);
    assign w_good     = (r_state == CHECK) && w_crc_ok;
    assign w_bad_crc  = (r_state == CHECK) && !w_crc_ok;
    assign w_timeout  = (r_state == BUSY) && !i_rd_valid && (r_timer == TMO_W'(TIMEOUT - 1));
    assign w_bad      = w_bad_crc || w_timeout;
    assign w_overrun  = w_tick && (r_state inside {START, BUSY, CHECK});
    assign w_retry_ok = RETRY_EN && (r_retry < RTY_W'(MAX_RETRY));
    assign o_rd_start = (r_state == START);

    // A disable always wins over a pending retry: the transfer in flight is the last one.
    assign w_after_bad = !i_enable ? IDLE : (w_retry_ok ? START : WAIT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                        r_tick_cnt <= '0;
        else if (!i_enable || w_tick)      r_tick_cnt <= '0;
        else                               r_tick_cnt <= r_tick_cnt + TCK_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_enable) w_next = WAIT;
            WAIT:    if (!i_enable) w_next = IDLE;
                     else if (w_tick) w_next = START;
            START:   w_next = BUSY;
            BUSY:    if (i_rd_valid) w_next = CHECK;
                     else if (w_timeout) w_next = w_after_bad;
            CHECK:   if (w_crc_ok) w_next = i_enable ? WAIT : IDLE;
                     else w_next = w_after_bad;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_timer      <= '0;
            r_frm_angle  <= '0;
            r_frm_status <= '0;
            r_frm_crc    <= '0;
        end else begin
            if (r_state == START)     r_timer <= '0;
            else if (r_state == BUSY) r_timer <= r_timer + TMO_W'(1);
            if (r_state == BUSY && i_rd_valid) begin
                r_frm_angle  <= i_rd_angle;
                r_frm_status <= i_rd_status;
                r_frm_crc    <= i_rd_crc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                                  r_retry <= '0;
        else if (w_tick || w_good)                   r_retry <= '0;
        else if (w_bad && w_retry_ok && i_enable)    r_retry <= r_retry + RTY_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_angle       <= '0;
            o_status      <= '0;
            o_angle_valid <= 1'b0;
        end else begin
            o_angle_valid <= w_good;
            if (w_good) begin
                o_angle  <= r_frm_angle;
                o_status <= r_frm_status;
            end
        end
    end

    // A clear coinciding with a bad frame still records that frame as the first of a new run.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_consec <= '0;
            o_fault  <= 1'b0;
        end else if (i_clr_fault) begin
            r_consec <= w_bad ? CON_W'(1) : '0;
            o_fault  <= 1'b0;
        end else if (w_good) begin
            r_consec <= '0;
        end else if (w_bad) begin
            if (r_consec < CON_W'(FAULT_LIMIT))       r_consec <= r_consec + CON_W'(1);
            if (r_consec >= CON_W'(FAULT_LIMIT - 1))  o_fault  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_crc_err_cnt <= '0;
            o_timeout_cnt <= '0;
            o_overrun_cnt <= '0;
        end else begin
            if (w_bad_crc && !(&o_crc_err_cnt)) o_crc_err_cnt <= o_crc_err_cnt + CNT_W'(1);
            if (w_timeout && !(&o_timeout_cnt)) o_timeout_cnt <= o_timeout_cnt + CNT_W'(1);
            if (w_overrun && !(&o_overrun_cnt)) o_overrun_cnt <= o_overrun_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mt6835_read_sched.sv
// Directed bench: instance A (PERIOD=100) with a reader model, instance B (PERIOD=1000) with a silent reader.
`timescale 1ns/1ps
module tb_mt6835_read_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, clr_a = 1'b0, vld_a = 1'b0;
    logic [20:0] angle_in = '0;
    logic [2:0]  status_in = '0;
    logic [7:0]  crc_in = '0;
    logic        start_a, avld_a, fault_a;
    logic [20:0] angle_a;
    logic [2:0]  status_a;
    logic [15:0] crc_cnt_a, to_cnt_a, ov_cnt_a;

    logic        en_b = 1'b0, clr_b = 1'b0, vld_b = 1'b0;
    logic        start_b, avld_b, fault_b;
    logic [20:0] angle_b;
    logic [2:0]  status_b;
    logic [15:0] crc_cnt_b, to_cnt_b, ov_cnt_b;

    int          n_checks = 0, n_errors = 0;
    int          n_start = 0, n_pub = 0, n_start_b = 0, n_pub_b = 0;
    int          rdr_lat = 40, rdr_bad = 0;
    logic [20:0] rdr_angle = 21'h0ABCDE;
    logic [2:0]  rdr_status = 3'd0;
    time         rdr_vld_t = 0, last_start_t = 0, start_iv = 0, pub_lat = 0;

    always #5 clk = ~clk;

    mt6835_read_sched #(.PERIOD(100), .TIMEOUT(512), .FAULT_LIMIT(4), .MAX_RETRY(2), .CNT_W(16)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_enable(en_a), .i_clr_fault(clr_a),
        .o_rd_start(start_a), .i_rd_valid(vld_a), .i_rd_angle(angle_in),
        .i_rd_status(status_in), .i_rd_crc(crc_in), .o_angle(angle_a), .o_status(status_a),
        .o_angle_valid(avld_a), .o_crc_err_cnt(crc_cnt_a), .o_timeout_cnt(to_cnt_a),
        .o_overrun_cnt(ov_cnt_a), .o_fault(fault_a));

    mt6835_read_sched #(.PERIOD(1000), .TIMEOUT(512), .FAULT_LIMIT(4), .MAX_RETRY(2), .CNT_W(16)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_enable(en_b), .i_clr_fault(clr_b),
        .o_rd_start(start_b), .i_rd_valid(vld_b), .i_rd_angle(angle_in),
        .i_rd_status(status_in), .i_rd_crc(crc_in), .o_angle(angle_b), .o_status(status_b),
        .o_angle_valid(avld_b), .o_crc_err_cnt(crc_cnt_b), .o_timeout_cnt(to_cnt_b),
        .o_overrun_cnt(ov_cnt_b), .o_fault(fault_b));

    // Reference CRC as polynomial long division of {frame, 8'h00} by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [20:0] a, input logic [2:0] s);
        logic [31:0] r;
        r = {a, s, 8'h00};
        for (int i = 31; i >= 8; i--)
            if (r[i]) r = r ^ (32'h107 << (i - 8));
        return r[7:0];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reader model: answers each o_rd_start after rdr_lat cycles; corrupts CRC bit 0 while rdr_bad > 0.
    always begin
        @(posedge clk);
        #1;
        if (start_a && rst_n) begin
            repeat (rdr_lat) @(posedge clk);
            #1;
            angle_in  = rdr_angle;
            status_in = rdr_status;
            crc_in    = ref_crc(rdr_angle, rdr_status) ^ ((rdr_bad > 0) ? 8'h01 : 8'h00);
            if (rdr_bad > 0) rdr_bad = rdr_bad - 1;
            rdr_vld_t = $time;
            vld_a     = 1'b1;
            @(posedge clk);
            #1;
            vld_a     = 1'b0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (start_a) begin
            n_start = n_start + 1;
            if (last_start_t != 0) start_iv = $time - last_start_t;
            last_start_t = $time;
        end
        if (avld_a) begin
            n_pub   = n_pub + 1;
            pub_lat = $time - rdr_vld_t;
        end
        if (start_b) n_start_b = n_start_b + 1;
        if (avld_b)  n_pub_b   = n_pub_b + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0;
        rdr_bad = 0; rdr_lat = 40; rdr_angle = 21'h0ABCDE; rdr_status = 3'd0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        n_start = 0; n_pub = 0; n_start_b = 0; n_pub_b = 0;
        last_start_t = 0; start_iv = 0; pub_lat = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({angle_a, status_a, avld_a, start_a, fault_a} !== 27'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %0h expected 0", {angle_a, status_a, avld_a, start_a, fault_a});
        end
        n_checks++;
        if ({crc_cnt_a, to_cnt_a, ov_cnt_a} !== 48'd0) begin
            n_errors++; $display("FAIL reset_counters: got %0h expected 0", {crc_cnt_a, to_cnt_a, ov_cnt_a});
        end
    endtask

    task automatic test_periodic();
        do_reset();
        en_a = 1'b1;
        cyc(350);
        n_checks++;
        if (n_start !== 3) begin n_errors++; $display("FAIL periodic_starts: got %0d expected 3", n_start); end
        n_checks++;
        if (start_iv !== 1000) begin n_errors++; $display("FAIL periodic_interval: got %0t expected 1000", start_iv); end
        n_checks++;
        if (n_pub !== 3) begin n_errors++; $display("FAIL periodic_pubs: got %0d expected 3", n_pub); end
        n_checks++;
        if (pub_lat !== 20) begin n_errors++; $display("FAIL publish_latency: got %0t expected 20", pub_lat); end
        n_checks++;
        if (angle_a !== 21'h0ABCDE || status_a !== 3'd0) begin
            n_errors++; $display("FAIL periodic_angle: got %h/%h expected 0abcde/0", angle_a, status_a);
        end
        n_checks++;
        if ({crc_cnt_a, to_cnt_a, ov_cnt_a, fault_a} !== 49'd0) begin
            n_errors++; $display("FAIL periodic_counters: got %0h expected 0", {crc_cnt_a, to_cnt_a, ov_cnt_a, fault_a});
        end
    endtask

    task automatic test_crc_fault();
        do_reset();
        rdr_bad = 4;
        en_a = 1'b1;
        cyc(350);
        n_checks++;
        if (crc_cnt_a !== 16'd3 || fault_a !== 1'b0) begin
            n_errors++; $display("FAIL crc_three_bad: got cnt %0d fault %0d expected 3/0", crc_cnt_a, fault_a);
        end
        cyc(100);
        n_checks++;
        if (crc_cnt_a !== 16'd4 || fault_a !== 1'b1) begin
            n_errors++; $display("FAIL crc_four_bad: got cnt %0d fault %0d expected 4/1", crc_cnt_a, fault_a);
        end
        n_checks++;
        if (angle_a !== 21'd0 || n_pub !== 0) begin
            n_errors++; $display("FAIL crc_no_publish: got angle %h pubs %0d expected 0/0", angle_a, n_pub);
        end
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        n_checks++;
        if (fault_a !== 1'b0) begin n_errors++; $display("FAIL clr_fault: got %0d expected 0", fault_a); end
        cyc(100);
        n_checks++;
        if (n_pub !== 1 || angle_a !== 21'h0ABCDE || crc_cnt_a !== 16'd4 || fault_a !== 1'b0) begin
            n_errors++; $display("FAIL crc_recover: got pubs %0d angle %h cnt %0d fault %0d expected 1/0abcde/4/0",
                                 n_pub, angle_a, crc_cnt_a, fault_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        en_b = 1'b1;
        cyc(1600);
        n_checks++;
        if (to_cnt_b !== 16'd1 || n_start_b !== 1) begin
            n_errors++; $display("FAIL timeout_first: got cnt %0d starts %0d expected 1/1", to_cnt_b, n_start_b);
        end
        cyc(2000);
        n_checks++;
        if (to_cnt_b !== 16'd3) begin n_errors++; $display("FAIL timeout_per_tick: got %0d expected 3", to_cnt_b); end
        n_checks++;
        if (n_pub_b !== 0 || angle_b !== 21'd0 || ov_cnt_b !== 16'd0 || fault_b !== 1'b0) begin
            n_errors++; $display("FAIL timeout_side: got pubs %0d angle %h ov %0d fault %0d expected 0/0/0/0",
                                 n_pub_b, angle_b, ov_cnt_b, fault_b);
        end
        en_b = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        rdr_lat = 150; rdr_angle = 21'h1F0F0F; rdr_status = 3'b101;
        en_a = 1'b1;
        cyc(460);
        n_checks++;
        if (ov_cnt_a !== 16'd2) begin n_errors++; $display("FAIL overrun_cnt: got %0d expected 2", ov_cnt_a); end
        n_checks++;
        if (n_pub !== 2 || angle_a !== 21'h1F0F0F || status_a !== 3'b101) begin
            n_errors++; $display("FAIL overrun_publish: got pubs %0d angle %h status %b expected 2/1f0f0f/101",
                                 n_pub, angle_a, status_a);
        end
        n_checks++;
        if (to_cnt_a !== 16'd0 || crc_cnt_a !== 16'd0) begin
            n_errors++; $display("FAIL overrun_side: got to %0d crc %0d expected 0/0", to_cnt_a, crc_cnt_a);
        end
    endtask

    task automatic test_disable_reset();
        do_reset();
        en_a = 1'b1;
        cyc(120);
        en_a = 1'b0;
        cyc(280);
        n_checks++;
        if (n_start !== 1 || n_pub !== 1 || angle_a !== 21'h0ABCDE) begin
            n_errors++; $display("FAIL disable_midbusy: got starts %0d pubs %0d angle %h expected 1/1/0abcde",
                                 n_start, n_pub, angle_a);
        end
        en_a = 1'b1;
        cyc(120);
        rst_n = 1'b0; en_a = 1'b0;
        #2;
        n_checks++;
        if ({angle_a, status_a, avld_a, start_a, fault_a, crc_cnt_a, to_cnt_a, ov_cnt_a} !== 75'd0) begin
            n_errors++; $display("FAIL reset_midbusy: got %0h expected 0",
                                 {angle_a, status_a, avld_a, start_a, fault_a, crc_cnt_a, to_cnt_a, ov_cnt_a});
        end
        cyc(5);
        rst_n = 1'b1;
        cyc(200);
        n_checks++;
        if (n_start !== 2 || n_pub !== 1 || angle_a !== 21'd0) begin
            n_errors++; $display("FAIL after_reset_idle: got starts %0d pubs %0d angle %h expected 2/1/0",
                                 n_start, n_pub, angle_a);
        end
    endtask

`ifdef MT6835_SCHED_RETRY_EN
    task automatic test_retry();
        do_reset();
        rdr_lat = 10; rdr_bad = 2;
        en_a = 1'b1;
        cyc(190);
        n_checks++;
        if (n_start !== 3 || crc_cnt_a !== 16'd2) begin
            n_errors++; $display("FAIL retry_starts: got starts %0d crc %0d expected 3/2", n_start, crc_cnt_a);
        end
        n_checks++;
        if (n_pub !== 1 || angle_a !== 21'h0ABCDE) begin
            n_errors++; $display("FAIL retry_publish: got pubs %0d angle %h expected 1/0abcde", n_pub, angle_a);
        end
    endtask
`else
    task automatic test_no_retry();
        do_reset();
        rdr_lat = 10; rdr_bad = 1;
        en_a = 1'b1;
        cyc(190);
        n_checks++;
        if (n_start !== 1 || crc_cnt_a !== 16'd1 || n_pub !== 0) begin
            n_errors++; $display("FAIL no_retry_wait: got starts %0d crc %0d pubs %0d expected 1/1/0",
                                 n_start, crc_cnt_a, n_pub);
        end
        cyc(60);
        n_checks++;
        if (n_start !== 2 || n_pub !== 1 || angle_a !== 21'h0ABCDE) begin
            n_errors++; $display("FAIL no_retry_next_tick: got starts %0d pubs %0d angle %h expected 2/1/0abcde",
                                 n_start, n_pub, angle_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_periodic();
        test_crc_fault();
        test_timeout();
        test_overrun();
        test_disable_reset();
`ifdef MT6835_SCHED_RETRY_EN
        test_retry();
`else
        test_no_retry();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
